// File: rtl/tlb_refill_ctrl.sv
// tlb_refill_ctrl: page-table walker shared by the ITLB and DTLB.
// Arbitrates level-sensitive miss requests (data side first), reads one PTE
// from a single-level table at ptbr + vpn*4, then either fills the requesting
// TLB or raises a page fault held until the pipeline kills it.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   ptbr              page table base byte address
//   d_miss/d_vpn      DTLB miss request and VPN
//   i_miss/i_vpn      ITLB miss request and VPN
//   kill              pipeline flush: abort walk / clear fault
//   mem_req/mem_addr  PTE read request (held until mem_ready)
//   mem_ready         request accepted
//   mem_rvalid/rdata  PTE response (bit31 valid, low PPN_W bits ppn)
//   d/i_write_en      one-cycle TLB fill strobes
//   write_vpn/ppn     fill translation
//   busy              walk or fault in progress
//   page_fault        invalid PTE, with fault_src (1=data) and fault_vpn
//   walk_count        completed fills, saturating
//   fault_count       faults, saturating
module tlb_refill_ctrl #(
  parameter int VPN_W  = 20,
  parameter int PPN_W  = 8,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ptbr,
  input  logic              d_miss,
  input  logic [VPN_W-1:0]  d_vpn,
  input  logic              i_miss,
  input  logic [VPN_W-1:0]  i_vpn,
  input  logic              kill,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              d_write_en,
  output logic              i_write_en,
  output logic [VPN_W-1:0]  write_vpn,
  output logic [PPN_W-1:0]  write_ppn,
  output logic              busy,
  output logic              page_fault,
  output logic              fault_src,
  output logic [VPN_W-1:0]  fault_vpn,
  output logic [CNT_W-1:0]  walk_count,
  output logic [CNT_W-1:0]  fault_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, FAULT, DRAIN} state_e;

  // Sum width covers both operands so the truncation to ADDR_W is explicit.
  localparam int SUM_W = (ADDR_W > VPN_W + 2) ? ADDR_W : VPN_W + 2;

  state_e              state_q, state_d;
  logic [VPN_W-1:0]    vpn_q, vpn_d;
  logic                src_q, src_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [VPN_W-1:0]    write_vpn_q, write_vpn_d;
  logic [PPN_W-1:0]    write_ppn_q, write_ppn_d;
  logic                fault_src_q, fault_src_d;
  logic [VPN_W-1:0]    fault_vpn_q, fault_vpn_d;
  logic [CNT_W-1:0]    walk_count_q, fault_count_q;
  logic                mem_req_q, busy_q, page_fault_q;
  logic                d_write_en_q, i_write_en_q;
  logic                walk_inc, fault_inc;
  logic [VPN_W-1:0]    sel_vpn;
  logic [SUM_W-1:0]    pte_sum;

  assign sel_vpn = d_miss ? d_vpn : i_vpn;
  assign pte_sum = SUM_W'(ptbr) + SUM_W'({sel_vpn, 2'b00});

  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    src_d       = src_q;
    mem_addr_d  = mem_addr_q;
    write_vpn_d = write_vpn_q;
    write_ppn_d = write_ppn_q;
    fault_src_d = fault_src_q;
    fault_vpn_d = fault_vpn_q;
    walk_inc    = 1'b0;
    fault_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!kill && (d_miss || i_miss)) begin
          vpn_d      = sel_vpn;
          src_d      = d_miss;
          mem_addr_d = pte_sum[ADDR_W-1:0];
          state_d    = REQ;
        end
      end
      REQ: begin
        // An accepted request must still have its response drained.
        if (mem_ready)  state_d = kill ? DRAIN : WAIT;
        else if (kill)  state_d = IDLE;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (kill) begin
            state_d = IDLE;
          end else if (mem_rdata[31]) begin
            write_vpn_d = vpn_q;
            write_ppn_d = mem_rdata[PPN_W-1:0];
            walk_inc    = 1'b1;
            state_d     = FILL;
          end else begin
            fault_src_d = src_q;
            fault_vpn_d = vpn_q;
            fault_inc   = 1'b1;
            state_d     = FAULT;
          end
        end else if (kill) begin
          state_d = DRAIN;
        end
      end
      FILL:    state_d = IDLE;
      FAULT:   if (kill) state_d = IDLE;
      DRAIN:   if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      vpn_q         <= '0;
      src_q         <= 1'b0;
      mem_addr_q    <= '0;
      write_vpn_q   <= '0;
      write_ppn_q   <= '0;
      fault_src_q   <= 1'b0;
      fault_vpn_q   <= '0;
      walk_count_q  <= '0;
      fault_count_q <= '0;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      page_fault_q  <= 1'b0;
      d_write_en_q  <= 1'b0;
      i_write_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      src_q        <= src_d;
      mem_addr_q   <= mem_addr_d;
      write_vpn_q  <= write_vpn_d;
      write_ppn_q  <= write_ppn_d;
      fault_src_q  <= fault_src_d;
      fault_vpn_q  <= fault_vpn_d;
      mem_req_q    <= (state_d == REQ);
      busy_q       <= (state_d != IDLE);
      page_fault_q <= (state_d == FAULT);
      d_write_en_q <= (state_d == FILL) && src_d;
      i_write_en_q <= (state_d == FILL) && !src_d;
      if (walk_inc && (walk_count_q != '1))
        walk_count_q <= walk_count_q + CNT_W'(1);
      if (fault_inc && (fault_count_q != '1))
        fault_count_q <= fault_count_q + CNT_W'(1);
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign d_write_en  = d_write_en_q;
  assign i_write_en  = i_write_en_q;
  assign write_vpn   = write_vpn_q;
  assign write_ppn   = write_ppn_q;
  assign busy        = busy_q;
  assign page_fault  = page_fault_q;
  assign fault_src   = fault_src_q;
  assign fault_vpn   = fault_vpn_q;
  assign walk_count  = walk_count_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ptbr = '0;
  logic        d_miss = 1'b0, i_miss = 1'b0, kill = 1'b0;
  logic [19:0] d_vpn = '0, i_vpn = '0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        mem_req, d_write_en, i_write_en, busy, page_fault, fault_src;
  logic [31:0] mem_addr;
  logic [19:0] write_vpn, fault_vpn;
  logic [7:0]  write_ppn;
  logic [15:0] walk_count, fault_count;

  logic        s_mem_req, s_dwe, s_iwe, s_busy, s_pf, s_fsrc;
  logic [31:0] s_mem_addr;
  logic [19:0] s_wvpn, s_fvpn;
  logic [7:0]  s_wppn;
  logic [1:0]  s_walk_count, s_fault_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlb_refill_ctrl #(.VPN_W(20), .PPN_W(8), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ptbr(ptbr),
    .d_miss(d_miss), .d_vpn(d_vpn), .i_miss(i_miss), .i_vpn(i_vpn), .kill(kill),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .d_write_en(d_write_en), .i_write_en(i_write_en),
    .write_vpn(write_vpn), .write_ppn(write_ppn), .busy(busy),
    .page_fault(page_fault), .fault_src(fault_src), .fault_vpn(fault_vpn),
    .walk_count(walk_count), .fault_count(fault_count)
  );

  tlb_refill_ctrl #(.VPN_W(20), .PPN_W(8), .ADDR_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ptbr(ptbr),
    .d_miss(d_miss), .d_vpn(d_vpn), .i_miss(i_miss), .i_vpn(i_vpn), .kill(kill),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .d_write_en(s_dwe), .i_write_en(s_iwe),
    .write_vpn(s_wvpn), .write_ppn(s_wppn), .busy(s_busy),
    .page_fault(s_pf), .fault_src(s_fsrc), .fault_vpn(s_fvpn),
    .walk_count(s_walk_count), .fault_count(s_fault_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    d_miss = 0; i_miss = 0; kill = 0; mem_ready = 0; mem_rvalid = 0;
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  // Memory responder: waits (bounded) for mem_req, accepts it, returns the
  // PTE on the next cycle; returns in the cycle after rvalid.
  task automatic serve_walk(input logic [31:0] pte, output logic ok,
                            output logic [31:0] addr);
    ok = 0;
    addr = '0;
    for (int n = 0; n < 20; n++) begin
      if (mem_req === 1'b1) begin ok = 1; break; end
      tick();
    end
    if (ok) begin
      addr = mem_addr;
      mem_ready = 1;
      tick();
      mem_ready = 0;
      mem_rvalid = 1;
      mem_rdata = pte;
      tick();
      mem_rvalid = 0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({mem_req, d_write_en, i_write_en, busy, page_fault, fault_src} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
        {mem_req, d_write_en, i_write_en, busy, page_fault, fault_src});
    end
    total++;
    if (mem_addr !== 32'h0 || write_vpn !== 20'h0 || write_ppn !== 8'h0 || fault_vpn !== 20'h0) begin
      bad++; $display("FAIL reset_data: got addr=%h wvpn=%h wppn=%h fvpn=%h want all 0",
        mem_addr, write_vpn, write_ppn, fault_vpn);
    end
    total++;
    if (walk_count !== 16'h0 || fault_count !== 16'h0) begin
      bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", walk_count, fault_count);
    end
  endtask

  task automatic test_data_walk();
    logic iwe_seen;
    apply_reset();
    ptbr = 32'h1000; d_vpn = 20'h00003; d_miss = 1;        // cycle 0
    iwe_seen = i_write_en;
    tick();                                                 // cycle 1
    iwe_seen |= i_write_en;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100C || busy !== 1'b1) begin
      bad++; $display("FAIL dw_req: got req=%b addr=%h busy=%b want 1 0000100c 1",
        mem_req, mem_addr, busy);
    end
    mem_ready = 1;
    tick();                                                 // cycle 2
    iwe_seen |= i_write_en;
    mem_ready = 0;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b1 || d_write_en !== 1'b0) begin
      bad++; $display("FAIL dw_wait: got req=%b busy=%b dwe=%b want 0 1 0",
        mem_req, busy, d_write_en);
    end
    tick();                                                 // cycle 3
    iwe_seen |= i_write_en;
    mem_rvalid = 1; mem_rdata = 32'h8000_0042;
    tick();                                                 // cycle 4
    iwe_seen |= i_write_en;
    mem_rvalid = 0;
    total++;
    if (d_write_en !== 1'b1 || write_vpn !== 20'h00003 || write_ppn !== 8'h42) begin
      bad++; $display("FAIL dw_fill: got dwe=%b vpn=%h ppn=%h want 1 00003 42",
        d_write_en, write_vpn, write_ppn);
    end
    total++;
    if (walk_count !== 16'd1) begin
      bad++; $display("FAIL dw_count: got %0d want 1", walk_count);
    end
    d_miss = 0;
    tick();                                                 // cycle 5
    iwe_seen |= i_write_en;
    total++;
    if (d_write_en !== 1'b0 || busy !== 1'b0 || iwe_seen !== 1'b0) begin
      bad++; $display("FAIL dw_done: got dwe=%b busy=%b iwe_seen=%b want 0 0 0",
        d_write_en, busy, iwe_seen);
    end
  endtask

  task automatic test_arbitration();
    logic ok;
    logic [31:0] addr;
    apply_reset();
    ptbr = 32'h1000;
    d_vpn = 20'h10; i_vpn = 20'h20; d_miss = 1; i_miss = 1;
    serve_walk(32'h8000_0011, ok, addr);
    total++;
    if (!ok || addr !== 32'h1040 || d_write_en !== 1'b1 || i_write_en !== 1'b0 ||
        write_vpn !== 20'h10 || write_ppn !== 8'h11) begin
      bad++; $display("FAIL arb_first: got ok=%b addr=%h dwe=%b iwe=%b vpn=%h ppn=%h want 1 00001040 1 0 00010 11",
        ok, addr, d_write_en, i_write_en, write_vpn, write_ppn);
    end
    d_miss = 0;
    serve_walk(32'h8000_0022, ok, addr);
    total++;
    if (!ok || addr !== 32'h1080 || i_write_en !== 1'b1 || d_write_en !== 1'b0 ||
        write_vpn !== 20'h20 || write_ppn !== 8'h22) begin
      bad++; $display("FAIL arb_second: got ok=%b addr=%h iwe=%b dwe=%b vpn=%h ppn=%h want 1 00001080 1 0 00020 22",
        ok, addr, i_write_en, d_write_en, write_vpn, write_ppn);
    end
    total++;
    if (walk_count !== 16'd2) begin
      bad++; $display("FAIL arb_count: got %0d want 2", walk_count);
    end
    i_miss = 0;
    tick();
    total++;
    if (busy !== 1'b0 || i_write_en !== 1'b0) begin
      bad++; $display("FAIL arb_idle: got busy=%b iwe=%b want 0 0", busy, i_write_en);
    end
  endtask

  task automatic test_kill_idle();
    apply_reset();
    ptbr = 32'h1000; d_vpn = 20'h9; d_miss = 1; kill = 1;
    tick();
    kill = 0;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL kill_idle: got req=%b busy=%b want 0 0", mem_req, busy);
    end
    d_miss = 0;
  endtask

  task automatic test_kill_wait();
    logic strobe;
    apply_reset();
    ptbr = 32'hFFFF_FFF0; d_vpn = 20'h7; d_miss = 1;        // cycle 0
    tick();                                                 // cycle 1
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_000C) begin
      bad++; $display("FAIL kw_addr_wrap: got req=%b addr=%h want 1 0000000c", mem_req, mem_addr);
    end
    mem_ready = 1;
    tick();                                                 // cycle 2 (WAIT)
    mem_ready = 0; kill = 1; d_miss = 0;
    tick();                                                 // cycle 3 (DRAIN)
    kill = 0;
    total++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL kw_drain: got busy=%b req=%b want 1 0", busy, mem_req);
    end
    tick();                                                 // cycle 4
    strobe = d_write_en | i_write_en;
    mem_rvalid = 1; mem_rdata = 32'h8000_0099;
    tick();                                                 // cycle 5
    mem_rvalid = 0;
    strobe |= d_write_en | i_write_en;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL kw_idle: got busy=%b want 0", busy);
    end
    tick();                                                 // cycle 6
    strobe |= d_write_en | i_write_en;
    total++;
    if (strobe !== 1'b0 || walk_count !== 16'd0) begin
      bad++; $display("FAIL kw_discard: got strobe=%b walks=%0d want 0 0", strobe, walk_count);
    end
  endtask

  task automatic test_fault();
    logic ok, held;
    logic [31:0] addr;
    apply_reset();
    ptbr = 32'h1000; i_vpn = 20'h5; i_miss = 1;
    serve_walk(32'h0000_0011, ok, addr);
    total++;
    if (!ok || page_fault !== 1'b1 || fault_src !== 1'b0 || fault_vpn !== 20'h5 || busy !== 1'b1) begin
      bad++; $display("FAIL flt_raise: got ok=%b pf=%b src=%b vpn=%h busy=%b want 1 1 0 00005 1",
        ok, page_fault, fault_src, fault_vpn, busy);
    end
    total++;
    if (fault_count !== 16'd1 || d_write_en !== 1'b0 || i_write_en !== 1'b0) begin
      bad++; $display("FAIL flt_count: got fc=%0d dwe=%b iwe=%b want 1 0 0",
        fault_count, d_write_en, i_write_en);
    end
    i_miss = 0;
    d_vpn = 20'h33; d_miss = 1;
    held = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (page_fault !== 1'b1 || fault_vpn !== 20'h5 || fault_src !== 1'b0 ||
          mem_req !== 1'b0 || fault_count !== 16'd1 || d_write_en !== 1'b0)
        held = 0;
    end
    total++;
    if (held !== 1'b1) begin
      bad++; $display("FAIL flt_hold: got held=%b pf=%b vpn=%h req=%b fc=%0d want 1 1 00005 0 1",
        held, page_fault, fault_vpn, mem_req, fault_count);
    end
    d_miss = 0; kill = 1;
    tick();
    kill = 0;
    total++;
    if (page_fault !== 1'b0 || busy !== 1'b0 || fault_count !== 16'd1) begin
      bad++; $display("FAIL flt_kill: got pf=%b busy=%b fc=%0d want 0 0 1",
        page_fault, busy, fault_count);
    end
  endtask

  task automatic test_backpressure_reset();
    logic stable;
    ptbr = 32'h2000; d_vpn = 20'hABCDE; d_miss = 1;
    tick();
    ptbr = 32'h3000;
    stable = 1;
    for (int c = 0; c < 4; c++) begin
      if (mem_req !== 1'b1 || mem_addr !== 32'h002B_1378) stable = 0;
      if (c < 3) tick();
    end
    total++;
    if (stable !== 1'b1) begin
      bad++; $display("FAIL bp_stable: got req=%b addr=%h want 1 002b1378", mem_req, mem_addr);
    end
    d_miss = 0; rst = 0;
    tick();
    rst = 1;
    total++;
    if ({mem_req, d_write_en, i_write_en, busy, page_fault, fault_src} !== 6'b0 ||
        mem_addr !== 32'h0 || fault_vpn !== 20'h0 || write_vpn !== 20'h0 ||
        write_ppn !== 8'h0 || walk_count !== 16'h0 || fault_count !== 16'h0) begin
      bad++; $display("FAIL bp_reset: got flags=%b addr=%h fvpn=%h fc=%0d want 0 00000000 00000 0",
        {mem_req, d_write_en, i_write_en, busy, page_fault, fault_src}, mem_addr, fault_vpn, fault_count);
    end
    mem_rvalid = 1; mem_rdata = 32'h8000_0077;
    tick();
    mem_rvalid = 0;
    tick();
    total++;
    if (d_write_en !== 1'b0 || i_write_en !== 1'b0 || busy !== 1'b0 || walk_count !== 16'h0) begin
      bad++; $display("FAIL bp_stray: got dwe=%b iwe=%b busy=%b wc=%0d want 0 0 0 0",
        d_write_en, i_write_en, busy, walk_count);
    end
    ptbr = 32'h1000;
  endtask

  task automatic test_saturation();
    logic ok;
    logic [31:0] addr;
    logic [1:0] exp_sat;
    apply_reset();
    ptbr = 32'h1000;
    for (int i = 1; i <= 5; i++) begin
      d_vpn = 20'(i); d_miss = 1;
      serve_walk(32'h8000_0000 | 32'(i), ok, addr);
      exp_sat = (i > 3) ? 2'd3 : 2'(i);
      total++;
      if (!ok || s_walk_count !== exp_sat || walk_count !== 16'(i) || s_dwe !== 1'b1) begin
        bad++; $display("FAIL sat_walk%0d: got ok=%b sat=%0d wide=%0d dwe=%b want 1 %0d %0d 1",
          i, ok, s_walk_count, walk_count, s_dwe, exp_sat, i);
      end
      d_miss = 0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_data_walk();
    test_arbitration();
    test_kill_idle();
    test_kill_wait();
    test_fault();
    test_backpressure_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
